line_burst_adaptor: RTL and testbench



---
 rtl/line_burst_adaptor_pkg.sv | 14 +
 rtl/line_beat_buffer.sv | 31 +++
 rtl/line_burst_adaptor.sv | 132 +++++++++++++
 tb/tb_line_burst_adaptor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_burst_adaptor_pkg.sv
// Shared types for the line-to-burst adaptor: FSM state encoding and
// default beat-count derived constants.
package line_burst_types;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int DEF_LINE_WIDTH = 256;
  localparam int DEF_BEAT_WIDTH = 64;
  localparam int BEATS          = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;
  localparam int BEAT_IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide storage register: whole-line load, per-beat write and
// combinational per-beat read, with a synchronous clear.
module line_beat_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  beat_we,
  input  logic [IDX_W-1:0]      beat_idx,
  input  logic [BEAT_WIDTH-1:0] beat_wdata,
  output logic [BEAT_WIDTH-1:0] beat_rdata,
  output logic [LINE_WIDTH-1:0] line_q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (beat_we) begin
      line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_wdata;
    end
  end

  assign beat_rdata = line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts single-line cache read/write requests into fixed-length beat
// bursts on the memory port and returns a one-cycle line response.
module line_burst_adaptor
  import line_burst_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int BEAT_CNT = LINE_WIDTH / BEAT_WIDTH;
  localparam int IDX_W    = (BEAT_CNT > 1) ? $clog2(BEAT_CNT) : 1;
  localparam int OFS_W    = $clog2(LINE_WIDTH / 8);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BEAT_CNT - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK  = ADDR_WIDTH'((1 << OFS_W) - 1);

  state_t                  state;
  logic [IDX_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_align;
  logic                    buf_load;
  logic                    buf_we;
  logic [BEAT_WIDTH-1:0]   buf_rdata;
  logic [LINE_WIDTH-1:0]   buf_line;

  // The last read beat lands in the buffer on the same edge that enters DONE,
  // so the published line is merged directly from burst_i.
  function automatic logic [LINE_WIDTH-1:0] with_last_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [BEAT_WIDTH-1:0] beat
  );
    with_last_beat = line;
    with_last_beat[(BEAT_CNT-1)*BEAT_WIDTH +: BEAT_WIDTH] = beat;
  endfunction

  assign addr_align = address_i & ~OFS_MASK;
  assign buf_load   = (state == IDLE) && !read_i && write_i;
  assign buf_we     = (state == READ) && resp_i;
  assign address_o  = addr_q;
  assign burst_o    = (state == WRITE) ? buf_rdata : '0;

  line_beat_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk        (clk),
    .clr        (rst),
    .load       (buf_load),
    .load_line  (line_i),
    .beat_we    (buf_we),
    .beat_idx   (cnt),
    .beat_wdata (burst_i),
    .beat_rdata (buf_rdata),
    .line_q     (buf_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      read_o  <= 1'b0;
      write_o <= 1'b0;
      resp_o  <= 1'b0;
      line_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          if (read_i) begin
            addr_q <= addr_align;
            cnt    <= '0;
            read_o <= 1'b1;
            state  <= READ;
          end else if (write_i) begin
            addr_q  <= addr_align;
            cnt     <= '0;
            write_o <= 1'b1;
            state   <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            if (cnt == LAST_IDX) begin
              cnt    <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              line_o <= with_last_beat(buf_line, burst_i);
              state  <= DONE;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (cnt == LAST_IDX) begin
              cnt     <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: read, gapped write, read/write
// priority, mid-burst reset, idle resp_i noise and back-to-back requests.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  line_burst_adaptor #(
    .LINE_WIDTH (256),
    .BEAT_WIDTH (64),
    .ADDR_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read burst with back-to-back acknowledges; hold keeps read_i high through DONE.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3, input bit hold);
    logic [63:0] bb [4];
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    address_i = addr;
    read_i    = 1'b1;
    tick();
    chk("rd_addr", 256'(address_o), 256'(exp_addr));
    if (!hold) read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      burst_i = bb[k];
      resp_i  = 1'b1;
      chk("rd_read_o", 256'(read_o), 256'(1'b1));
      chk("rd_resp_o_early", 256'(resp_o), 256'(1'b0));
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    chk("rd_done_resp", 256'(resp_o), 256'(1'b1));
    chk("rd_done_read_o", 256'(read_o), 256'(1'b0));
    chk("rd_line", line_o, {b3, b2, b1, b0});
    tick();
    read_i = 1'b0;
    chk("rd_after_resp", 256'(resp_o), 256'(1'b0));
    chk("rd_after_read_o", 256'(read_o), 256'(1'b0));
    chk("rd_line_hold", line_o, {b3, b2, b1, b0});
  endtask

  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;

  initial begin
    logic [255:0] read_line;
    logic [255:0] new_line;
    logic         pat [7];
    logic [63:0]  exp_burst [7];
    logic [63:0]  wb [4];

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    tick();
    tick();
    chk("rst_read_o", 256'(read_o), 256'(1'b0));
    chk("rst_write_o", 256'(write_o), 256'(1'b0));
    chk("rst_resp_o", 256'(resp_o), 256'(1'b0));
    chk("rst_line_o", line_o, 256'(0));
    chk("rst_burst_o", 256'(burst_o), 256'(0));
    chk("rst_address_o", 256'(address_o), 256'(0));
    rst = 1'b0;
    tick();

    // Contiguous read, address aligned to 32-byte line.
    run_read(32'h0000_1234, 32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0);
    read_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    // Write with acknowledge gaps.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    exp_burst[0] = BA; exp_burst[1] = BB; exp_burst[2] = BB; exp_burst[3] = BB;
    exp_burst[4] = BC; exp_burst[5] = BD; exp_burst[6] = BD;
    line_i    = {BD, BC, BB, BA};
    address_i = 32'h0000_2010;
    write_i   = 1'b1;
    tick();
    write_i = 1'b0;
    line_i  = '0;
    chk("wr_addr", 256'(address_o), 256'(32'h0000_2000));
    for (int k = 0; k < 7; k++) begin
      resp_i = pat[k];
      chk("wr_write_o", 256'(write_o), 256'(1'b1));
      chk("wr_burst_o", 256'(burst_o), 256'(exp_burst[k]));
      chk("wr_resp_o_early", 256'(resp_o), 256'(1'b0));
      tick();
    end
    resp_i = 1'b0;
    chk("wr_done_resp", 256'(resp_o), 256'(1'b1));
    chk("wr_done_write_o", 256'(write_o), 256'(1'b0));
    chk("wr_line_unchanged", line_o, read_line);
    tick();
    chk("wr_after_resp", 256'(resp_o), 256'(1'b0));

    // Simultaneous read and write requests: read wins.
    line_i    = {4{64'hFEED_FEED_FEED_FEED}};
    address_i = 32'h0000_0040;
    read_i    = 1'b1;
    write_i   = 1'b1;
    tick();
    read_i = 1'b0;
    write_i = 1'b0;
    chk("both_read_o", 256'(read_o), 256'(1'b1));
    chk("both_addr", 256'(address_o), 256'(32'h0000_0040));
    for (int k = 0; k < 4; k++) begin
      burst_i = {8{8'(8'h55 + 8'(k) * 8'h11)}};
      resp_i  = 1'b1;
      chk("both_write_o", 256'(write_o), 256'(1'b0));
      tick();
    end
    resp_i = 1'b0;
    chk("both_done_resp", 256'(resp_o), 256'(1'b1));
    read_line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    chk("both_line", line_o, read_line);
    tick();

    // Reset during the third beat of a read.
    address_i = 32'h0000_0080;
    read_i    = 1'b1;
    tick();
    read_i = 1'b0;
    burst_i = 64'h9999_9999_9999_9999; resp_i = 1'b1; tick();
    burst_i = 64'h9898_9898_9898_9898; resp_i = 1'b1; tick();
    burst_i = 64'h9797_9797_9797_9797; resp_i = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_i = 1'b0;
    chk("abort_read_o", 256'(read_o), 256'(1'b0));
    chk("abort_resp_o", 256'(resp_o), 256'(1'b0));
    chk("abort_line_o", line_o, 256'(0));
    chk("abort_address_o", 256'(address_o), 256'(0));
    tick();
    chk("abort_no_resp", 256'(resp_o), 256'(1'b0));
    run_read(32'h0000_00C4, 32'h0000_00C0, 64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
             64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4, 1'b0);
    read_line = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                 64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1};

    // resp_i noise while idle.
    resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_resp_o", 256'(resp_o), 256'(1'b0));
      chk("idle_read_o", 256'(read_o), 256'(1'b0));
      chk("idle_write_o", 256'(write_o), 256'(1'b0));
      chk("idle_line_o", line_o, read_line);
    end
    resp_i = 1'b0;
    tick();

    // Back-to-back: read held through DONE, write two cycles later.
    run_read(32'h0000_0100, 32'h0000_0100, 64'hEEEE_EEEE_EEEE_EEEE, 64'h0F0F_0F0F_0F0F_0F0F,
             64'h1212_1212_1212_1212, 64'h3434_3434_3434_3434, 1'b1);
    read_line = {64'h3434_3434_3434_3434, 64'h1212_1212_1212_1212,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'hEEEE_EEEE_EEEE_EEEE};
    tick();
    chk("b2b_gap_read_o", 256'(read_o), 256'(1'b0));
    wb[0] = 64'h0123_4567_89AB_CDEF; wb[1] = 64'h1032_5476_98BA_DCFE;
    wb[2] = 64'h2301_6745_AB89_EFCD; wb[3] = 64'h3210_7654_BA98_FEDC;
    new_line  = {wb[3], wb[2], wb[1], wb[0]};
    line_i    = new_line;
    address_i = 32'h0000_0200;
    write_i   = 1'b1;
    tick();
    write_i = 1'b0;
    chk("b2b_write_o", 256'(write_o), 256'(1'b1));
    chk("b2b_no_read", 256'(read_o), 256'(1'b0));
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      chk("b2b_burst_o", 256'(burst_o), 256'(wb[k]));
      tick();
    end
    resp_i = 1'b0;
    chk("b2b_done_resp", 256'(resp_o), 256'(1'b1));
    chk("b2b_line_kept", line_o, read_line);
    tick();
    tick();
    chk("b2b_end_read_o", 256'(read_o), 256'(1'b0));
    chk("b2b_end_write_o", 256'(write_o), 256'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
